// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants and state encoding for the NTT layer controller
package ntt_pkg;

    localparam int N          = 256;
    localparam int ADDR_WIDTH = 8;
    localparam int LOG_N      = 8;
    localparam int NUM_LAYERS = 7;
    localparam int TW_WIDTH   = 7;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

endpackage

// File: rtl/ntt_addr_tracker.sv
// rtl/ntt_addr_tracker.sv - {valid, addr} write-back delay line with outstanding-butterfly counter
module ntt_addr_tracker #(
    parameter int DEPTH = 9,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_valid,
    input  logic [AW-1:0] push_addr,
    output logic          pop_valid,
    output logic [AW-1:0] pop_addr,
    output logic          drained_next
);

    localparam int CW = $clog2(DEPTH + 1);

    logic          valid_q [DEPTH];
    logic [AW-1:0] addr_q  [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;

    always_comb begin
        count_nxt = count_q;
        if (push_valid && !pop_valid) begin
            count_nxt = count_q + CW'(1);
        end else if (!push_valid && pop_valid) begin
            count_nxt = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
            end
            count_q <= '0;
        end else begin
            valid_q[0] <= push_valid;
            addr_q[0]  <= push_addr;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
            count_q <= count_nxt;
        end
    end

    assign pop_valid    = valid_q[DEPTH-1];
    assign pop_addr     = addr_q[DEPTH-1];
    // Looking at the next count lets the FSM restart on the cycle of the final write-back.
    assign drained_next = (count_nxt == '0);

endmodule

// File: rtl/ntt_layer_controller.sv
// rtl/ntt_layer_controller.sv - Kyber NTT layer sequencer; NTT_LAYER_CTRL_INTT_EN adds inverse-order support
module ntt_layer_controller
    import ntt_pkg::*;
#(
    parameter int BFU_LATENCY = 8,
    parameter int RD_LATENCY  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef NTT_LAYER_CTRL_INTT_EN
    input  logic                  inverse,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  bf_valid_in,
    output logic [TW_WIDTH-1:0]   bf_twiddle_idx,
    input  logic                  bf_valid_out,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr_a,
    output logic [ADDR_WIDTH-1:0] wr_addr_b,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] LEN_FWD0   = ADDR_WIDTH'(N / 2);
    localparam logic [ADDR_WIDTH-1:0] LEN_INV0   = ADDR_WIDTH'(2);
    localparam logic [TW_WIDTH-1:0]   K_FWD0     = TW_WIDTH'(1);
    localparam logic [TW_WIDTH-1:0]   K_INV0     = TW_WIDTH'((1 << TW_WIDTH) - 1);
    localparam logic [2:0]            LAST_LAYER = 3'(NUM_LAYERS - 1);

    state_t                state;
    logic [2:0]            layer;
    logic [ADDR_WIDTH-1:0] len;
    logic [ADDR_WIDTH-1:0] j;
    logic [ADDR_WIDTH-1:0] grp;
    logic [TW_WIDTH-1:0]   k;
    logic                  inv_q;
    logic                  start_inv;
    logic                  drained_next;

`ifdef NTT_LAYER_CTRL_INTT_EN
    assign start_inv = inverse;
`else
    assign start_inv = 1'b0;
`endif

    logic [ADDR_WIDTH:0]   grp_sum;
    logic                  group_end;
    logic                  layer_end;
    logic [ADDR_WIDTH-1:0] j_nxt;
    logic [ADDR_WIDTH-1:0] grp_nxt;
    logic [TW_WIDTH-1:0]   k_nxt;
    logic [ADDR_WIDTH-1:0] len_start;
    logic [ADDR_WIDTH-1:0] len_next_layer;

    // The carry out of grp + 2*len marks the last group of a layer.
    assign grp_sum        = {1'b0, grp} + {len, 1'b0};
    assign group_end      = (j == len - ADDR_WIDTH'(1));
    assign layer_end      = group_end && grp_sum[ADDR_WIDTH];
    assign len_start      = start_inv ? LEN_INV0 : LEN_FWD0;
    assign len_next_layer = inv_q ? (len << 1) : (len >> 1);

    always_comb begin
        j_nxt   = j + ADDR_WIDTH'(1);
        grp_nxt = grp;
        k_nxt   = k;
        if (group_end) begin
            j_nxt   = '0;
            grp_nxt = grp_sum[ADDR_WIDTH-1:0];
            k_nxt   = inv_q ? (k - TW_WIDTH'(1)) : (k + TW_WIDTH'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            layer     <= '0;
            len       <= '0;
            j         <= '0;
            grp       <= '0;
            k         <= '0;
            inv_q     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        inv_q     <= start_inv;
                        layer     <= '0;
                        len       <= len_start;
                        j         <= '0;
                        grp       <= '0;
                        k         <= start_inv ? K_INV0 : K_FWD0;
                        rd_en     <= 1'b1;
                        rd_addr_a <= '0;
                        rd_addr_b <= len_start;
                    end
                end
                ISSUE: begin
                    k <= k_nxt;
                    if (layer_end) begin
                        state <= DRAIN;
                        rd_en <= 1'b0;
                    end else begin
                        j         <= j_nxt;
                        grp       <= grp_nxt;
                        rd_addr_a <= grp_nxt + j_nxt;
                        rd_addr_b <= grp_nxt + j_nxt + len;
                    end
                end
                DRAIN: begin
                    if (drained_next) begin
                        if (layer == LAST_LAYER) begin
                            state <= FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= ISSUE;
                            layer     <= layer + 3'd1;
                            len       <= len_next_layer;
                            j         <= '0;
                            grp       <= '0;
                            rd_en     <= 1'b1;
                            rd_addr_a <= '0;
                            rd_addr_b <= len_next_layer;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic                tw_valid_q [RD_LATENCY];
    logic [TW_WIDTH-1:0] tw_idx_q   [RD_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                tw_valid_q[i] <= 1'b0;
                tw_idx_q[i]   <= '0;
            end
        end else begin
            tw_valid_q[0] <= rd_en;
            tw_idx_q[0]   <= k;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tw_valid_q[i] <= tw_valid_q[i-1];
                tw_idx_q[i]   <= tw_idx_q[i-1];
            end
        end
    end

    assign bf_valid_in    = tw_valid_q[RD_LATENCY-1];
    assign bf_twiddle_idx = tw_idx_q[RD_LATENCY-1];

    ntt_addr_tracker #(
        .DEPTH (RD_LATENCY + BFU_LATENCY),
        .AW    (ADDR_WIDTH)
    ) u_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid   (rd_en),
        .push_addr    (rd_addr_a),
        .pop_valid    (wr_en),
        .pop_addr     (wr_addr_a),
        .drained_next (drained_next)
    );

    // len is held through the drain, so the b address is rebuilt at the tail.
    assign wr_addr_b = wr_addr_a + len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (wr_en != bf_valid_out) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ntt_layer_controller.sv
// tb/tb_ntt_layer_controller.sv - directed self-checking bench for ntt_layer_controller
module tb_ntt_layer_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       bf_valid_out;
    logic       busy, done, rd_en, bf_valid_in, wr_en, err;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] bf_twiddle_idx;

    always #5 clk = ~clk;

    ntt_layer_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
`ifdef NTT_LAYER_CTRL_INTT_EN
        .inverse        (1'b0),
`endif
        .busy           (busy),
        .done           (done),
        .rd_en          (rd_en),
        .rd_addr_a      (rd_addr_a),
        .rd_addr_b      (rd_addr_b),
        .bf_valid_in    (bf_valid_in),
        .bf_twiddle_idx (bf_twiddle_idx),
        .bf_valid_out   (bf_valid_out),
        .wr_en          (wr_en),
        .wr_addr_a      (wr_addr_a),
        .wr_addr_b      (wr_addr_b),
        .err            (err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Butterfly model: fixed latency of 8, with an optional single dropped result.
    logic [7:0] bfu_sr = 8'h00;
    bit         drop_en = 1'b0;
    int         drop_cyc = 0;
    always @(posedge clk) begin
        if (!rst_n) bfu_sr <= 8'h00;
        else        bfu_sr <= {bfu_sr[6:0], bf_valid_in};
    end
    assign bf_valid_out = bfu_sr[7] && !(drop_en && cyc == drop_cyc);

    localparam int S_RD_EN = 0, S_RA = 1, S_RB = 2, S_BVI = 3, S_TW = 4;
    localparam int S_WR_EN = 5, S_WA = 6, S_WB = 7, S_DONE = 8, S_BUSY = 9;
    localparam int NP = 34;

    typedef struct {
        int off;
        int sig;
        int exp;
    } probe_t;

    probe_t probes [NP];
    string  sig_name [10] = '{"rd_en", "rd_addr_a", "rd_addr_b", "bf_valid_in", "twiddle_idx",
                              "wr_en", "wr_addr_a", "wr_addr_b", "done", "busy"};

    function automatic int sig_val(input int s);
        case (s)
            S_RD_EN: return int'(rd_en);
            S_RA:    return int'(rd_addr_a);
            S_RB:    return int'(rd_addr_b);
            S_BVI:   return int'(bf_valid_in);
            S_TW:    return int'(bf_twiddle_idx);
            S_WR_EN: return int'(wr_en);
            S_WA:    return int'(wr_addr_a);
            S_WB:    return int'(wr_addr_b);
            S_DONE:  return int'(done);
            default: return int'(busy);
        endcase
    endfunction

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    int t0 = 0;
    int rd_cnt, wr_cnt, done_cnt, done_off, first_wr_off, last_wr_off;
    int gap, gap_cnt, gap_bad;
    bit in_run = 1'b0;
    bit probe_en = 1'b0;

    task automatic clear_mon();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_off = -1;
        first_wr_off = -1; last_wr_off = -1;
        gap = 0; gap_cnt = 0; gap_bad = 0; in_run = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rd_en) rd_cnt++;
        if (wr_en) begin
            if (first_wr_off < 0) first_wr_off = cyc - t0;
            last_wr_off = cyc - t0;
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_off = cyc - t0;
        end
        if (in_run) begin
            if (rd_en) begin
                if (gap > 0) begin
                    gap_cnt++;
                    if (gap != 9) gap_bad++;
                end
                gap = 0;
            end else if (done) begin
                gap_cnt++;
                if (gap != 9) gap_bad++;
                gap = 0;
                in_run = 1'b0;
            end else begin
                gap++;
            end
        end else if (rd_en) begin
            in_run = 1'b1;
            gap = 0;
        end
        if (probe_en) begin
            for (int i = 0; i < NP; i++) begin
                if (cyc - t0 == probes[i].off)
                    check($sformatf("%s@T+%0d", sig_name[probes[i].sig], probes[i].off),
                          sig_val(probes[i].sig), probes[i].exp);
            end
        end
    end

    task automatic start_run();
        @(negedge clk);
        t0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1500 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(name, int'(seen), 1);
    endtask

    initial begin
        probes = '{
            '{1,   S_RD_EN, 1},   '{1,   S_RA, 0},      '{1,   S_RB, 128},   '{1,   S_BUSY, 1},
            '{1,   S_BVI, 0},     '{2,   S_BVI, 1},     '{2,   S_TW, 1},     '{2,   S_RA, 1},
            '{2,   S_RB, 129},    '{9,   S_WR_EN, 0},   '{10,  S_WR_EN, 1},  '{10,  S_WA, 0},
            '{10,  S_WB, 128},    '{128, S_RA, 127},    '{128, S_RB, 255},   '{129, S_RD_EN, 0},
            '{137, S_WR_EN, 1},   '{137, S_WA, 127},    '{137, S_WB, 255},   '{138, S_RD_EN, 1},
            '{138, S_RB, 64},     '{139, S_TW, 2},      '{202, S_RA, 128},   '{202, S_RB, 192},
            '{203, S_TW, 3},      '{950, S_RA, 253},    '{950, S_RB, 255},   '{951, S_TW, 127},
            '{959, S_WR_EN, 1},   '{959, S_WA, 253},    '{959, S_WB, 255},   '{960, S_DONE, 1},
            '{960, S_BUSY, 0},    '{961, S_DONE, 0}
        };
        clear_mon();

        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_rd_en", int'(rd_en), 0);
        check("reset_rd_addr_a", int'(rd_addr_a), 0);
        check("reset_rd_addr_b", int'(rd_addr_b), 0);
        check("reset_bf_valid_in", int'(bf_valid_in), 0);
        check("reset_twiddle", int'(bf_twiddle_idx), 0);
        check("reset_wr_en", int'(wr_en), 0);
        check("reset_wr_addr_a", int'(wr_addr_a), 0);
        check("reset_wr_addr_b", int'(wr_addr_b), 0);
        check("reset_err", int'(err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full forward run, with stray starts mid-run and in the FINISH cycle.
        clear_mon();
        probe_en = 1'b1;
        start_run();
        wait_cyc(t0 + 50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("run1_done_seen");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        probe_en = 1'b0;
        check("run1_rd_count", rd_cnt, 896);
        check("run1_wr_count", wr_cnt, 896);
        check("run1_done_offset", done_off, 960);
        check("run1_done_count", done_cnt, 1);
        check("run1_first_wr", first_wr_off, 10);
        check("run1_last_wr", last_wr_off, 959);
        check("run1_gap_count", gap_cnt, 7);
        check("run1_gap_bad", gap_bad, 0);
        check("run1_err", int'(err), 0);
        check("run1_busy_after", int'(busy), 0);

        // One dropped butterfly result must latch err.
        clear_mon();
        start_run();
        drop_cyc = t0 + 500;
        drop_en = 1'b1;
        wait_done("run2_done_seen");
        check("drop_err_at_done", int'(err), 1);
        repeat (5) @(negedge clk);
        check("drop_err_sticky", int'(err), 1);
        check("drop_wr_count", wr_cnt, 896);
        drop_en = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("err_cleared_by_reset", int'(err), 0);

        // Reset mid-transform aborts, then a fresh run completes normally.
        clear_mon();
        start_run();
        wait_cyc(t0 + 300);
        rst_n = 1'b0;
        #1;
        check("abort_wr_en", int'(wr_en), 0);
        check("abort_rd_en", int'(rd_en), 0);
        check("abort_busy", int'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("wr_en_in_reset_%0d", i), int'(wr_en), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        start_run();
        wait_done("run3_done_seen");
        repeat (3) @(negedge clk);
        check("run3_done_offset", done_off, 960);
        check("run3_rd_count", rd_cnt, 896);
        check("run3_wr_count", wr_cnt, 896);
        check("run3_err", int'(err), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
